// File: rtl/complex_ap_result_collector.sv
// -----------------------------------------------------------------------------
// complex_ap_result_collector
//
// Downstream stage of the complex dot-product controller. Collects a stream of
// scalar complex results (one per result_valid), packs them NO_OF_UNITS per
// memory word and writes the words to the AP_total memory. The image is padded
// with zero lanes and zero words so that it is always TOTAL elements long.
// A one-cycle done pulse follows the final write.
//
// Optional build macro: COMPLEX_AP_COLLECT_ERR_CHECK_EN
//   defined   -> err is a sticky flag for extra results / start while busy
//   undefined -> err is tied to 0, no check logic
//
// Ports:
//   clk           clock
//   reset         synchronous active-high reset
//   start         one-cycle pulse, begins a collection run (ignored when busy/done)
//   result_in     complex result, [63:32] real, [31:0] imaginary (stored bit-exact)
//   result_valid  result_in valid this cycle
//   wr_en         AP_total write strobe, one pulse per word
//   wr_addr       word address 0..TOTAL_WORDS-1 (held between writes)
//   wr_data       packed word, lane k at [(k+1)*ELEMENT_WIDTH-1 : k*ELEMENT_WIDTH]
//   busy          high while collecting or flushing
//   done          one-cycle pulse after the last word is written
//   err           sticky protocol error (see macro above)
// -----------------------------------------------------------------------------
module complex_ap_result_collector #(
    parameter int NOE           = 16,
    parameter int ELEMENT_WIDTH = 64,
    parameter int NO_OF_UNITS   = 8,
    parameter int ADDR_WIDTH    = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [ELEMENT_WIDTH-1:0]             result_in,
    input  logic                                 result_valid,
    output logic                                 wr_en,
    output logic [ADDR_WIDTH-1:0]                wr_addr,
    output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] wr_data,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);

    localparam int ADDITIONAL  = NO_OF_UNITS - (NOE % NO_OF_UNITS);
    localparam int TOTAL       = NOE + ADDITIONAL;
    localparam int TOTAL_WORDS = TOTAL / NO_OF_UNITS;
    localparam int LANE_W      = (NO_OF_UNITS > 1) ? $clog2(NO_OF_UNITS) : 1;
    localparam int CNT_W       = $clog2(NOE + 1);
    localparam int WORD_W      = ELEMENT_WIDTH * NO_OF_UNITS;

    localparam logic [LANE_W-1:0]     LANE_LAST = LANE_W'(NO_OF_UNITS - 1);
    localparam logic [CNT_W-1:0]      ELEM_LAST = CNT_W'(NOE - 1);
    localparam logic [ADDR_WIDTH-1:0] WORD_LAST = ADDR_WIDTH'(TOTAL_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                  state_reg;
    logic [CNT_W-1:0]        elem_cnt_reg;
    logic [LANE_W-1:0]       lane_reg;
    logic [ADDR_WIDTH-1:0]   word_cnt_reg;
    logic [ELEMENT_WIDTH-1:0] lane_buf_reg [NO_OF_UNITS];

    logic [WORD_W-1:0] word_next;
    logic              last_elem;
    logic              word_close;

    assign last_elem  = (elem_cnt_reg == ELEM_LAST);
    assign word_close = (lane_reg == LANE_LAST) || last_elem;

    // Word as it looks once the incoming element lands in its lane. The buffer
    // is cleared after each emitted word, so lanes above the current one are
    // already zero -- this is what zero-fills a short final data word.
    generate
        for (genvar gi = 0; gi < NO_OF_UNITS; gi++) begin : g_lane
            assign word_next[gi*ELEMENT_WIDTH +: ELEMENT_WIDTH] =
                (lane_reg == LANE_W'(gi)) ? result_in : lane_buf_reg[gi];
        end
    endgenerate

    assign busy = (state_reg == S_COLLECT) || (state_reg == S_FLUSH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            elem_cnt_reg <= '0;
            lane_reg     <= '0;
            word_cnt_reg <= '0;
            for (int i = 0; i < NO_OF_UNITS; i++) begin
                lane_buf_reg[i] <= '0;
            end
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    // done is high on the first IDLE cycle after a run; a start
                    // landing there is ignored.
                    if (start && !done) begin
                        state_reg    <= S_COLLECT;
                        elem_cnt_reg <= '0;
                        lane_reg     <= '0;
                        word_cnt_reg <= '0;
                    end
                end
                S_COLLECT: begin
                    if (result_valid) begin
                        elem_cnt_reg <= elem_cnt_reg + 1'b1;
                        if (word_close) begin
                            // Emit straight from the merged word; the buffer is
                            // free next cycle so lane 0 of the next word can be
                            // captured while this one is being written.
                            wr_en        <= 1'b1;
                            wr_addr      <= word_cnt_reg;
                            wr_data      <= word_next;
                            word_cnt_reg <= word_cnt_reg + 1'b1;
                            lane_reg     <= '0;
                            for (int i = 0; i < NO_OF_UNITS; i++) begin
                                lane_buf_reg[i] <= '0;
                            end
                            if (last_elem) begin
                                state_reg <= (word_cnt_reg == WORD_LAST) ? S_DONE : S_FLUSH;
                            end
                        end else begin
                            lane_buf_reg[lane_reg] <= result_in;
                            lane_reg               <= lane_reg + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    wr_en        <= 1'b1;
                    wr_addr      <= word_cnt_reg;
                    wr_data      <= '0;
                    word_cnt_reg <= word_cnt_reg + 1'b1;
                    if (word_cnt_reg == WORD_LAST) begin
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    done      <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

`ifdef COMPLEX_AP_COLLECT_ERR_CHECK_EN
    logic err_reg;

    // Any result outside COLLECT is surplus; the FSM drops it independently.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_reg <= 1'b0;
        end else if ((result_valid && (state_reg != S_COLLECT)) || (start && busy)) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_complex_ap_result_collector.sv
// -----------------------------------------------------------------------------
// Bench for complex_ap_result_collector. Two instances: NOE=16 (a, exact
// multiple of the word size, one flush word) and NOE=20 (b, short final word,
// no flush). Expected writes are built from the list of accepted results by
// chunking them into words and zero-padding the image to TOTAL elements.
// -----------------------------------------------------------------------------
module tb_complex_ap_result_collector;

    localparam int EW = 64;
    localparam int U  = 8;
    localparam int AW = 8;
    localparam int WW = EW * U;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          start_a, valid_a, wr_en_a, busy_a, done_a, err_a;
    logic [EW-1:0] res_a;
    logic [AW-1:0] wr_addr_a;
    logic [WW-1:0] wr_data_a;

    logic          start_b, valid_b, wr_en_b, busy_b, done_b, err_b;
    logic [EW-1:0] res_b;
    logic [AW-1:0] wr_addr_b;
    logic [WW-1:0] wr_data_b;

    complex_ap_result_collector #(
        .NOE(16), .ELEMENT_WIDTH(EW), .NO_OF_UNITS(U), .ADDR_WIDTH(AW)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .result_in(res_a),
        .result_valid(valid_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    complex_ap_result_collector #(
        .NOE(20), .ELEMENT_WIDTH(EW), .NO_OF_UNITS(U), .ADDR_WIDTH(AW)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .result_in(res_b),
        .result_valid(valid_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    typedef struct packed {
        logic [31:0]   cyc;
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } wr_t;

    wr_t wq_a[$];
    wr_t wq_b[$];
    int  dq_a[$];
    int  dq_b[$];

    int checks   = 0;
    int failures = 0;
    bit err_exp_a = 1'b0;
    bit err_exp_b = 1'b0;

    // Monitor: log every write and done pulse with its cycle stamp.
    always @(negedge clk) begin
        if (wr_en_a) wq_a.push_back('{cyc: cyc, addr: wr_addr_a, data: wr_data_a});
        if (wr_en_b) wq_b.push_back('{cyc: cyc, addr: wr_addr_b, data: wr_data_b});
        if (done_a)  dq_a.push_back(cyc);
        if (done_b)  dq_b.push_back(cyc);
    end

    task automatic check_val(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int which, input logic st, input logic v, input logic [EW-1:0] val);
        if (which == 0) begin
            start_a = st; valid_a = v; res_a = val;
        end else begin
            start_b = st; valid_b = v; res_b = val;
        end
    endtask

    function automatic logic [EW-1:0] gen_val(input int mode, input int i);
        logic [EW-1:0] v;
        case (mode)
            0:       v = EW'(i + 1);
            1:       v = 64'h0000_0001_0000_0002;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // One collection run plus full comparison of the write stream.
    task automatic do_run(input int which, input string name, input int n_noe, input int n_extra,
                          input int gmin, input int gmax, input bit v_with_start, input int mode);
        logic [EW-1:0] vals[$];
        int            vcyc[$];
        wr_t           q[$];
        int            d[$];
        logic [WW-1:0] expw;
        logic [EW-1:0] v;
        int            tw, expc, last_idx, idx, gap;
        bit            seen;

        tw = (n_noe + U - (n_noe % U)) / U;
        if (which == 0) begin wq_a.delete(); dq_a.delete(); end
        else            begin wq_b.delete(); dq_b.delete(); end

        @(posedge clk); #1;
        drive(which, 1'b1, v_with_start, 64'hDEAD_BEEF_0BAD_F00D);
        for (int i = 0; i < n_noe + n_extra; i++) begin
            @(posedge clk); #1;
            v = gen_val(mode, i);
            drive(which, 1'b0, 1'b1, v);
            if (i < n_noe) begin
                vals.push_back(v);
                vcyc.push_back(cyc);
            end
            gap = $urandom_range(gmax, gmin);
            repeat (gap) begin
                @(posedge clk); #1;
                drive(which, 1'b0, 1'b0, '0);
            end
        end
        @(posedge clk); #1;
        drive(which, 1'b0, 1'b0, '0);

`ifdef COMPLEX_AP_COLLECT_ERR_CHECK_EN
        if (n_extra > 0 || v_with_start) begin
            if (which == 0) err_exp_a = 1'b1;
            else            err_exp_b = 1'b1;
        end
`endif

        seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if ((which == 0) ? (dq_a.size() != 0) : (dq_b.size() != 0)) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
        end
        repeat (4) @(posedge clk);
        #1;
        check_val($sformatf("%s_done_seen", name), WW'(seen), WW'(1));

        if (which == 0) begin q = wq_a; d = dq_a; end
        else            begin q = wq_b; d = dq_b; end

        check_val($sformatf("%s_nwrites", name), WW'(q.size()), WW'(tw));
        expc = 0;
        for (int w = 0; w < tw; w++) begin
            expw = '0;
            for (int j = 0; j < U; j++) begin
                idx = w * U + j;
                if (idx < n_noe) expw[j*EW +: EW] = vals[idx];
            end
            if (w * U < n_noe) begin
                last_idx = ((w + 1) * U < n_noe) ? (w + 1) * U - 1 : n_noe - 1;
                expc = vcyc[last_idx] + 1;
            end else begin
                expc = expc + 1;
            end
            if (w < q.size()) begin
                $display("%s word %0d addr=%0d cyc=%0d exp_cyc=%0d", name, w, q[w].addr, q[w].cyc, expc);
                check_val($sformatf("%s_w%0d_addr", name, w), WW'(q[w].addr), WW'(w));
                check_val($sformatf("%s_w%0d_data", name, w), q[w].data, expw);
                check_val($sformatf("%s_w%0d_cyc", name, w), WW'(q[w].cyc), WW'(expc));
            end
        end
        check_val($sformatf("%s_ndone", name), WW'(d.size()), WW'(1));
        if (d.size() > 0) check_val($sformatf("%s_done_cyc", name), WW'(d[0]), WW'(expc + 1));
        check_val($sformatf("%s_busy_after", name), WW'((which == 0) ? busy_a : busy_b), WW'(0));
        check_val($sformatf("%s_err", name), WW'((which == 0) ? err_a : err_b),
                  WW'((which == 0) ? err_exp_a : err_exp_b));
    endtask

    // Reset after the 10th valid of a 16-element run on instance a.
    task automatic abort_a();
        logic [WW-1:0] expw;
        wq_a.delete(); dq_a.delete();
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            drive(0, 1'b0, 1'b1, gen_val(0, i));
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        err_exp_a = 1'b0;
        err_exp_b = 1'b0;
        check_val("abort_busy", WW'(busy_a), WW'(0));
        check_val("abort_addr_cleared", WW'(wr_addr_a), WW'(0));
        check_val("abort_data_cleared", wr_data_a, '0);
        repeat (20) @(posedge clk);
        #1;
        expw = '0;
        for (int j = 0; j < U; j++) expw[j*EW +: EW] = EW'(j + 1);
        $display("abort writes=%0d done=%0d", wq_a.size(), dq_a.size());
        check_val("abort_nwrites", WW'(wq_a.size()), WW'(1));
        if (wq_a.size() > 0) check_val("abort_w0_data", wq_a[0].data, expw);
        check_val("abort_ndone", WW'(dq_a.size()), WW'(0));
        check_val("abort_busy_later", WW'(busy_a), WW'(0));
        check_val("abort_err", WW'(err_a), WW'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, '0);
        drive(1, 1'b0, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_val("rst_a_wr_en", WW'(wr_en_a), WW'(0));
        check_val("rst_a_addr",  WW'(wr_addr_a), WW'(0));
        check_val("rst_a_data",  wr_data_a, '0);
        check_val("rst_a_busy",  WW'(busy_a), WW'(0));
        check_val("rst_a_done",  WW'(done_a), WW'(0));
        check_val("rst_a_err",   WW'(err_a), WW'(0));
        check_val("rst_b_wr_en", WW'(wr_en_b), WW'(0));
        check_val("rst_b_busy",  WW'(busy_b), WW'(0));

        do_run(0, "a_seq",      16, 0, 0, 0, 1'b0, 0);
        abort_a();
        do_run(0, "a_clean",    16, 0, 0, 0, 1'b0, 2);
        do_run(0, "a_rand_gap", 16, 0, 0, 3, 1'b0, 2);
        do_run(0, "a_extra",    16, 1, 0, 0, 1'b0, 2);
        do_run(0, "a_vstart",   16, 0, 0, 1, 1'b1, 2);
        do_run(1, "b_fixed",    20, 0, 2, 2, 1'b0, 1);
        do_run(1, "b_rand",     20, 0, 0, 2, 1'b0, 2);

        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_val("final_rst_a_err", WW'(err_a), WW'(0));
        check_val("final_rst_b_err", WW'(err_b), WW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
